alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational 64-bit ALU between `NREQ` requesters (e.g. execute stage, address generation, CSR unit) through valid/ready handshakes. Grants are round-robin. The block registers the ALU result and returns it to the winning requester with a valid/ready response. It sits between the issue logic and the ALU, and owns the ALU's operand and op-select inputs.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `CNT_W`, 32: width of the contention counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle, one-hot or zero.
- `req_a`  in  NREQ*64  operand A; slice i is bits [64i+63:64i].
- `req_b`  in  NREQ*64  operand B, same packing as `req_a`.
- `req_op`  in  NREQ*4  op select; slice i is bits [4i+3:4i].
- `resp_valid`  out  NREQ  result valid for requester i, one-hot or zero.
- `resp_data`  out  64  registered ALU result.
- `resp_ready`  in  NREQ  requester i accepts the result.
- `busy`  out  1  a result is held and not yet accepted.
- `contention_cnt`  out  CNT_W  count of cycles with two or more `req_valid` bits set.

## Operation
- Op encoding:
  - 0 add, 1 sub (A−B), 2 and, 3 or, 4 xor.
  - 5 signed less-than, 6 unsigned less-than; the result is a 0/1 zero-extended to 64 bits.
  - 7 sll, 8 srl, 9 sra, each by `B[5:0]`.
  - 10..15 produce 64'd0.
- All arithmetic is modulo 2^64.
- State machine, two states:
  - IDLE: no result held.
  - HOLD: a result is held in `resp_data` for owner `own`.
- Response fire `rfire` = HOLD && `resp_ready[own]`. Acceptance window `open` = IDLE || `rfire`.
- Arbitration:
  - Pointer `last` holds the index of the most recently granted requester.
  - The candidate is the first set `req_valid` bit scanning `last+1, last+2, …` modulo NREQ.
  - The grant depends only on `req_valid` and `last`, never on operand values.
- `req_ready[cand]` = `open`; all other `req_ready` bits are 0.
  - Accept `afire` = `open` && a candidate exists.
  - On `afire`: the ALU output for the candidate's operands is captured into `resp_data`, `own`←cand, `last`←cand, next state HOLD.
  - On `rfire` without `afire`: next state IDLE.
  - With both, the block stays in HOLD with the new result. This gives back-to-back throughput of one op per cycle.
- `resp_valid[i]` = HOLD && `own`==i. `busy` = HOLD.
- `resp_data` holds its value until the next `afire`, including while IDLE.
- Requesters keep `req_valid`, operands and op stable until `req_ready`. Dropping `req_valid` early is legal: the request is then simply never taken.
- `contention_cnt` increments by 1 every cycle where popcount(`req_valid`) ≥ 2, independent of state. It saturates at all-ones.

## Timing
- Reset values:
  - State IDLE; `resp_valid`=0, `busy`=0, `resp_data`=0.
  - `own`=0, `last`=NREQ−1, so requester 0 has first priority.
  - `contention_cnt`=0.
- Reset mid-operation discards any held result with no response. A request visible during a reset cycle is not accepted: `req_ready`=0 while `reset` is high.
- Latency: a request accepted at edge T has `resp_valid` high in the cycle after T.
- `req_ready` depends combinationally on `resp_ready` through `rfire`. `resp_valid`, `resp_data` and `busy` are pure register outputs.
- A single requester streaming with `resp_ready` tied high gets one result per cycle.
- A stalled response (`resp_ready[own]`=0) blocks all new accepts. Waiting requesters see `req_ready`=0.
- A `resp_ready` bit for a non-owner, or any `resp_ready` while IDLE, is ignored.

## Test plan
- After reset: requester 0 sends op 0, A=5, B=7 -> `req_ready[0]`=1; next cycle `resp_valid`=01 and `resp_data`=12; with `resp_ready[0]`=1 the block returns to IDLE.
- Ops 1/5/6/9 with A=64'h8000_0000_0000_0000, B=1, then op 9 with B=64'd65 -> sub gives 64'h7FFF_FFFF_FFFF_FFFF, slt 1, sltu 0; sra with B=1 gives 64'hC000_0000_0000_0000; sra with B=65 also gives 64'hC000_0000_0000_0000 (B[5:0]=1).
- NREQ=2, both valid every cycle, `resp_ready`=11 -> grants alternate 0,1,0,1; `contention_cnt` increments every cycle; one result per cycle.
- Owner holds `resp_ready`=0 for 3 cycles while the other requester is valid -> `req_ready`=00 for those cycles, `resp_data` is stable; the other requester is granted in the same cycle `resp_ready` rises.
- Reset asserted while in HOLD -> next cycle `resp_valid`=0, `busy`=0, `resp_data`=0, `contention_cnt`=0; the next simultaneous request grants requester 0.
- Op 12 with nonzero operands -> `resp_data`=0. Force `contention_cnt` near all-ones with CNT_W=4 -> it stops at 4'hF.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational 64-bit ALU among NREQ
// requesters; the result is registered and returned over a valid/ready response.
module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    input  logic [NREQ*4-1:0]  req_op,
    output logic [NREQ-1:0]    resp_valid,
    output logic [63:0]        resp_data,
    input  logic [NREQ-1:0]    resp_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   contention_cnt
);
    localparam int IDX_W = (NREQ > 2) ? 2 : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] own_q;
    logic [IDX_W-1:0] last_q;
    logic [63:0]      data_q;
    logic [NREQ-1:0]  resp_valid_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [63:0] a_arr  [NREQ];
    logic [63:0] b_arr  [NREQ];
    logic [3:0]  op_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[64*gi +: 64];
            assign b_arr[gi]  = req_b[64*gi +: 64];
            assign op_arr[gi] = req_op[4*gi +: 4];
        end
    endgenerate

    // Round-robin scan starting just after the most recently granted index.
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] scan;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan       = last_q;
        for (int k = 0; k < NREQ; k++) begin
            scan = (scan == IDX_W'(NREQ - 1)) ? '0 : scan + IDX_W'(1);
            if (!cand_found && req_valid[scan]) begin
                cand_found = 1'b1;
                cand_idx   = scan;
            end
        end
    end

    logic [63:0] a_sel;
    logic [63:0] b_sel;
    logic [3:0]  op_sel;
    logic [63:0] alu_res;

    assign a_sel  = a_arr[cand_idx];
    assign b_sel  = b_arr[cand_idx];
    assign op_sel = op_arr[cand_idx];

    always_comb begin
        alu_res = '0;
        case (op_sel)
            4'd0:    alu_res = a_sel + b_sel;
            4'd1:    alu_res = a_sel - b_sel;
            4'd2:    alu_res = a_sel & b_sel;
            4'd3:    alu_res = a_sel | b_sel;
            4'd4:    alu_res = a_sel ^ b_sel;
            4'd5:    alu_res = {63'd0, $signed(a_sel) < $signed(b_sel)};
            4'd6:    alu_res = {63'd0, a_sel < b_sel};
            4'd7:    alu_res = a_sel << b_sel[5:0];
            4'd8:    alu_res = a_sel >> b_sel[5:0];
            4'd9:    alu_res = $unsigned($signed(a_sel) >>> b_sel[5:0]);
            default: alu_res = '0;
        endcase
    end

    // A response handshake frees the result register in the same cycle, so a
    // new request can be accepted while the previous result is being taken.
    logic rfire;
    logic open_win;
    logic afire;

    assign rfire    = (state_q == HOLD) && resp_ready[own_q];
    assign open_win = !reset && ((state_q == IDLE) || rfire);
    assign afire    = open_win && cand_found;

    always_comb begin
        req_ready = '0;
        if (afire) begin
            req_ready[cand_idx] = 1'b1;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more are set.
    logic multi_req;
    assign multi_req = |(req_valid & (req_valid - NREQ'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (multi_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            own_q        <= '0;
            last_q       <= IDX_W'(NREQ - 1);
            data_q       <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (afire) begin
                        state_q      <= HOLD;
                        data_q       <= alu_res;
                        own_q        <= cand_idx;
                        last_q       <= cand_idx;
                        resp_valid_q <= req_ready;
                        busy_q       <= 1'b1;
                    end
                end
                HOLD: begin
                    if (afire) begin
                        data_q       <= alu_res;
                        own_q        <= cand_idx;
                        last_q       <= cand_idx;
                        resp_valid_q <= req_ready;
                    end else if (rfire) begin
                        state_q      <= IDLE;
                        resp_valid_q <= '0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_data      = data_q;
    assign busy           = busy_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors and sequences on a 2-requester instance,
// randomized traffic against a reference model on a 4-requester, 4-bit-counter instance.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NREQ=2, CNT_W=32
    logic         rst2;
    logic [1:0]   r2_valid, r2_ready, r2_resp_valid, r2_resp_ready;
    logic [127:0] r2_a, r2_b;
    logic [7:0]   r2_op;
    logic [63:0]  r2_resp_data;
    logic         r2_busy;
    logic [31:0]  r2_cnt;

    alu_arbiter #(.NREQ(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .reset(rst2),
        .req_valid(r2_valid), .req_ready(r2_ready),
        .req_a(r2_a), .req_b(r2_b), .req_op(r2_op),
        .resp_valid(r2_resp_valid), .resp_data(r2_resp_data),
        .resp_ready(r2_resp_ready), .busy(r2_busy), .contention_cnt(r2_cnt)
    );

    // Instance B: NREQ=4, CNT_W=4
    logic         rst4;
    logic [3:0]   r4_valid, r4_ready, r4_resp_valid, r4_resp_ready;
    logic [255:0] r4_a, r4_b;
    logic [15:0]  r4_op;
    logic [63:0]  r4_resp_data;
    logic         r4_busy;
    logic [3:0]   r4_cnt;

    alu_arbiter #(.NREQ(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(rst4),
        .req_valid(r4_valid), .req_ready(r4_ready),
        .req_a(r4_a), .req_b(r4_b), .req_op(r4_op),
        .resp_valid(r4_resp_valid), .resp_data(r4_resp_data),
        .resp_ready(r4_resp_ready), .busy(r4_busy), .contention_cnt(r4_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU built from the operation definitions, not from shifts of signed types.
    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] r;
        logic [63:0] ones;
        int sh;
        ones = ~64'd0;
        sh   = int'(b % 64);
        r    = 64'd0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a + (~b) + 64'd1;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin
                if (a[63] != b[63]) r = {63'd0, a[63]};
                else                r = {63'd0, a < b};
            end
            4'd6: r = {63'd0, a < b};
            4'd7: r = a * (64'd1 << sh);
            4'd8: r = a / (64'd1 << sh);
            4'd9: begin
                r = a / (64'd1 << sh);
                if (a[63]) r = r | ~(ones >> sh);
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[15];

    // Random-phase model state and requester-side bookkeeping
    logic [3:0]  pend;
    logic [63:0] pa[4];
    logic [63:0] pb[4];
    logic [3:0]  pop[4];
    logic [3:0]  rr;
    logic        m_held;
    int          m_own, m_last, cand;
    logic [63:0] m_data;
    logic [3:0]  m_cnt;
    logic        m_open;
    logic [3:0]  exp_ready, exp_rv;

    initial begin
        vecs[0]  = '{"add",        4'd0,  64'd5, 64'd7, 64'd12};
        vecs[1]  = '{"sub_min",    4'd1,  64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{"slt_min",    4'd5,  64'h8000_0000_0000_0000, 64'd1, 64'd1};
        vecs[3]  = '{"sltu_min",   4'd6,  64'h8000_0000_0000_0000, 64'd1, 64'd0};
        vecs[4]  = '{"sra_1",      4'd9,  64'h8000_0000_0000_0000, 64'd1, 64'hC000_0000_0000_0000};
        vecs[5]  = '{"sra_65",     4'd9,  64'h8000_0000_0000_0000, 64'd65, 64'hC000_0000_0000_0000};
        vecs[6]  = '{"op12",       4'd12, 64'h1234, 64'h5678, 64'd0};
        vecs[7]  = '{"sub_wrap",   4'd1,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{"and",        4'd2,  64'hF0F0, 64'h0FF0, 64'h00F0};
        vecs[9]  = '{"or",         4'd3,  64'hF000, 64'h000F, 64'hF00F};
        vecs[10] = '{"xor",        4'd4,  64'hFF, 64'h0F, 64'hF0};
        vecs[11] = '{"sll_63",     4'd7,  64'd1, 64'd63, 64'h8000_0000_0000_0000};
        vecs[12] = '{"srl_68",     4'd8,  64'h8000_0000_0000_0000, 64'd68, 64'h0800_0000_0000_0000};
        vecs[13] = '{"add_wrap",   4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
        vecs[14] = '{"sltu_big",   4'd6,  64'd1, 64'h8000_0000_0000_0000, 64'd1};

        rst2 = 1'b1; r2_valid = 2'b01; r2_a = '0; r2_b = '0; r2_op = '0; r2_resp_ready = '0;
        rst4 = 1'b1; r4_valid = '0;    r4_a = '0; r4_b = '0; r4_op = '0; r4_resp_ready = '0;
        pend = '0;

        // Reset state; a request visible during reset is not accepted
        tick();
        @(negedge clk);
        chk("ready_in_reset", 64'(r2_ready), 64'd0);
        chk("rst_resp_valid", 64'(r2_resp_valid), 64'd0);
        chk("rst_busy", 64'(r2_busy), 64'd0);
        chk("rst_data", r2_resp_data, 64'd0);
        chk("rst_cnt", 64'(r2_cnt), 64'd0);
        tick();
        rst2 = 1'b0; r2_valid = 2'b00;

        // Table-driven ALU vectors through requester 0
        for (int v = 0; v < 15; v++) begin
            r2_valid = 2'b01; r2_op[3:0] = vecs[v].op; r2_a[63:0] = vecs[v].a;
            r2_b[63:0] = vecs[v].b; r2_resp_ready = 2'b01;
            @(negedge clk);
            chk({vecs[v].name, "_idle_busy"}, 64'(r2_busy), 64'd0);
            chk({vecs[v].name, "_ready"}, 64'(r2_ready), 64'd1);
            tick();
            r2_valid = 2'b00;
            @(negedge clk);
            chk({vecs[v].name, "_resp_valid"}, 64'(r2_resp_valid), 64'd1);
            chk({vecs[v].name, "_data"}, r2_resp_data, vecs[v].exp);
            $display("vec %-10s op=%0d a=%h b=%h -> %h", vecs[v].name, vecs[v].op,
                     vecs[v].a, vecs[v].b, r2_resp_data);
            tick();
        end

        // Both requesters streaming: grants alternate, one result per cycle
        rst2 = 1'b1; tick(); rst2 = 1'b0;
        r2_valid = 2'b11; r2_a = {64'd200, 64'd100}; r2_b = {64'd1, 64'd1}; r2_op = 8'h00;
        r2_resp_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("alt_ready", 64'(r2_ready), 64'(2'b01 << (c % 2)));
            chk("alt_cnt", 64'(r2_cnt), 64'(c));
            if (c > 0) begin
                chk("alt_resp_valid", 64'(r2_resp_valid), 64'(2'b01 << ((c - 1) % 2)));
                chk("alt_data", r2_resp_data, ((c - 1) % 2 == 0) ? 64'd101 : 64'd201);
            end
            $display("alt cycle %0d ready=%b resp_valid=%b data=%0d", c, r2_ready,
                     r2_resp_valid, r2_resp_data);
            tick();
        end

        // Owner (requester 1) stalls for 3 cycles; the non-owner's resp_ready is ignored
        r2_resp_ready = 2'b01;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_ready", 64'(r2_ready), 64'd0);
            chk("stall_resp_valid", 64'(r2_resp_valid), 64'd2);
            chk("stall_data", r2_resp_data, 64'd201);
            tick();
        end
        r2_resp_ready = 2'b10;
        @(negedge clk);
        chk("unstall_ready", 64'(r2_ready), 64'd1);
        chk("unstall_cnt", 64'(r2_cnt), 64'd9);
        tick();
        @(negedge clk);
        chk("unstall_resp_valid", 64'(r2_resp_valid), 64'd1);
        chk("unstall_data", r2_resp_data, 64'd101);
        r2_valid = 2'b00; r2_resp_ready = 2'b11;
        tick();

        // Reset while holding a result
        r2_valid = 2'b10; r2_a = {64'd3, 64'd0}; r2_b = {64'd4, 64'd0}; r2_resp_ready = 2'b00;
        @(negedge clk);
        chk("hold_ready", 64'(r2_ready), 64'd2);
        tick();
        @(negedge clk);
        chk("hold_busy", 64'(r2_busy), 64'd1);
        chk("hold_data", r2_resp_data, 64'd7);
        rst2 = 1'b1; r2_valid = 2'b11;
        @(negedge clk);
        chk("rst_hold_ready", 64'(r2_ready), 64'd0);
        tick();
        rst2 = 1'b0; r2_resp_ready = 2'b11;
        @(negedge clk);
        chk("post_rst_resp_valid", 64'(r2_resp_valid), 64'd0);
        chk("post_rst_busy", 64'(r2_busy), 64'd0);
        chk("post_rst_data", r2_resp_data, 64'd0);
        chk("post_rst_cnt", 64'(r2_cnt), 64'd0);
        chk("post_rst_ready", 64'(r2_ready), 64'd1);
        r2_valid = 2'b00;
        tick();

        // Randomized traffic on the 4-requester instance
        rst4 = 1'b0;
        m_held = 1'b0; m_own = 0; m_last = 3; m_data = 64'd0; m_cnt = 4'd0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[i] = 1'b1;
                        pa[i]   = {$urandom, $urandom};
                        pb[i]   = ($urandom_range(3) == 0) ? 64'($urandom_range(130))
                                                           : {$urandom, $urandom};
                        pop[i]  = 4'($urandom_range(15));
                    end
                end else if ($urandom_range(24) == 0) begin
                    pend[i] = 1'b0;
                end
                rr[i] = ($urandom_range(3) != 0);
            end
            r4_valid      = pend;
            r4_a          = {pa[3], pa[2], pa[1], pa[0]};
            r4_b          = {pb[3], pb[2], pb[1], pb[0]};
            r4_op         = {pop[3], pop[2], pop[1], pop[0]};
            r4_resp_ready = rr;
            @(negedge clk);
            m_open = !m_held || rr[m_own];
            cand   = -1;
            for (int k = 1; k <= 4; k++) begin
                if (cand < 0 && pend[(m_last + k) % 4]) cand = (m_last + k) % 4;
            end
            exp_ready = (m_open && cand >= 0) ? 4'(1 << cand) : 4'd0;
            exp_rv    = m_held ? 4'(1 << m_own) : 4'd0;
            chk("rand_ready", 64'(r4_ready), 64'(exp_ready));
            chk("rand_resp_valid", 64'(r4_resp_valid), 64'(exp_rv));
            chk("rand_busy", 64'(r4_busy), 64'(m_held));
            chk("rand_data", r4_resp_data, m_data);
            chk("rand_cnt", 64'(r4_cnt), 64'(m_cnt));
            if ($countones(pend) >= 2 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (m_open && cand >= 0) begin
                m_data = alu_ref(pop[cand], pa[cand], pb[cand]);
                m_own  = cand;
                m_last = cand;
                m_held = 1'b1;
                pend[cand] = 1'b0;
                $display("rand cyc %0d grant req=%0d op=%0d result=%h", cyc, cand,
                         pop[cand], m_data);
            end else if (m_held && rr[m_own]) begin
                m_held = 1'b0;
            end
            tick();
        end

        // Contention counter saturation with a 4-bit counter
        rst4 = 1'b1; r4_valid = 4'b0000; pend = '0;
        tick();
        rst4 = 1'b0; r4_valid = 4'b0011; r4_resp_ready = 4'hF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("sat_cnt", 64'(r4_cnt), (k > 15) ? 64'd15 : 64'(k));
            tick();
        end
        $display("saturation: cnt=%h", r4_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
